// File: rtl/bcd_down_counter.sv
// bcd_down_counter: cascadable synchronous BCD down counter with parallel
// load, two count enables (EP parallel, ET trickle), ripple borrow out and
// zero flag. Asynchronous clear; clear release is resynchronised to CLK.
module bcd_down_counter #(
   parameter int DIGITS = 2
) (
   input  logic                  CLK,
   input  logic                  _RD,
   input  logic                  _LD,
   input  logic                  EP,
   input  logic                  ET,
   input  logic [4*DIGITS-1:0]   D,
   output logic [4*DIGITS-1:0]   Q,
   output logic                  B,
   output logic                  Z
);

   localparam int W = 4 * DIGITS;

   // Reject unsupported decade counts at elaboration time.
   generate
      if ((DIGITS < 1) || (DIGITS > 4)) begin : g_bad_digits
         $error("bcd_down_counter: DIGITS must be in 1..4");
      end
   endgenerate

   // Next value of one stepping decade: 0 wraps to 9, invalid codes
   // (10..15) are forced to 9, anything else decrements.
   function automatic logic [3:0] digit_dec(input logic [3:0] d);
      logic [3:0] r;
      if ((d == 4'd0) || (d > 4'd9)) begin
         r = 4'd9;
      end else begin
         r = d - 4'd1;
      end
      return r;
   endfunction

   logic [1:0]   rst_sync_r;
   logic         run_s;
   logic [W-1:0] q_dec_s;
   logic         step_s;

   // Two-flop release synchroniser; cleared asynchronously by _RD.
   always_ff @(posedge CLK or negedge _RD) begin
      if (!_RD) begin
         rst_sync_r <= 2'b00;
      end else begin
         rst_sync_r <= {rst_sync_r[0], 1'b1};
      end
   end

   // Operations are allowed from the second edge after _RD rises onward.
   assign run_s = |rst_sync_r;

   // Decimal decrement with digit-wise borrow; only a true 0 borrows.
   always_comb begin
      q_dec_s = Q;
      step_s  = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         if (step_s) begin
            q_dec_s[4*k +: 4] = digit_dec(Q[4*k +: 4]);
         end else begin
            q_dec_s[4*k +: 4] = Q[4*k +: 4];
         end
         step_s = step_s & (Q[4*k +: 4] == 4'd0);
      end
   end

   // Count register: clear, then load, then count, then hold.
   always_ff @(posedge CLK or negedge _RD) begin
      if (!_RD) begin
         Q <= {W{1'b0}};
      end else if (run_s) begin
         if (!_LD) begin
            Q <= D;
         end else if (EP && ET) begin
            Q <= q_dec_s;
         end else begin
            Q <= Q;
         end
      end else begin
         Q <= Q;
      end
   end

   // Zero flag and trickle-gated borrow out for cascading.
   always_comb begin
      Z = (Q == {W{1'b0}});
      B = ET & Z;
   end

endmodule
